// File: rtl/zap_ifetch_wb_master_if.sv
// Wishbone B3 classic read-side bundle between the instruction fetch master and memory.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by withholding ack/err.
interface zap_ifetch_wb_master_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] o_wb_adr;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_we, o_wb_sel,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_we, o_wb_sel,
        output i_wb_dat, i_wb_ack, i_wb_err
    );
endinterface

// File: rtl/zap_ifetch_wb_master.sv
// Instruction fetch Wishbone master: single classic reads at the writeback PC, word presented to fetch.
// Latency: issue edge -> cyc high; o_valid rises on the edge that samples ack/err/timeout.
// Backpressure: i_stall holds the output register and blocks new issues; i_clear flushes, in-flight cycles drain.
module zap_ifetch_wb_master #(
    parameter int          TIMEOUT       = 256,
    parameter logic [31:0] ABORT_PAYLOAD = 32'd0
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [31:0]                i_pc,
    input  logic                       i_fetch_en,
    input  logic                       i_stall,
    input  logic                       i_clear,
    output logic [31:0]                o_instruction,
    output logic                       o_valid,
    output logic                       o_instr_abort,
    output logic [31:0]                o_pc,
    zap_ifetch_wb_master_if.master     wb
);

    localparam int             CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic          r_cyc;
    logic [31:0]   r_adr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_instruction;
    logic [31:0]   r_pc;
    logic          r_valid;
    logic          r_abort;

    logic          w_busy;
    logic          w_timeout;
    logic          w_resp;
    logic          w_fail;
    logic          w_issue;
    logic          w_load;
    logic          w_unused;

    // Only word addresses are fetched; the byte offset of the PC is dropped.
    assign w_unused  = ^i_pc[1:0];

    assign w_busy    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign w_timeout = w_busy && (r_count == C_LAST);
    assign w_resp    = w_busy && (i_wb_ack_q() || wb.i_wb_err || w_timeout);
    // err wins over ack; a timeout only counts when the slave is silent.
    assign w_fail    = wb.i_wb_err || (w_timeout && !wb.i_wb_ack);
    // An empty output is guaranteed by issuing only when fetch is not stalled.
    assign w_issue   = (r_state == S_IDLE) && i_fetch_en && !i_clear && !i_stall;
    // A clear on the response edge discards the response.
    assign w_load    = (r_state == S_REQ) && w_resp && !i_clear;

    function automatic logic i_wb_ack_q();
        return wb.i_wb_ack;
    endfunction

    // Bus sequencer: issue from IDLE, wait in REQ, swallow flushed responses in DRAIN.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_adr   <= 32'd0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_cyc   <= 1'b1;
                        r_adr   <= {i_pc[31:2], 2'b00};
                        r_count <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ, S_DRAIN: begin
                    if (w_resp) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Saturate so the count never wraps inside a transaction.
                        if (!w_timeout) begin
                            r_count <= r_count + 1'b1;
                        end
                        // The cycle stays on the bus; only its response is dropped.
                        if ((r_state == S_REQ) && i_clear) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: clear beats a response, a response beats consumption.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_instruction <= 32'd0;
            r_pc          <= 32'd0;
            r_valid       <= 1'b0;
            r_abort       <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_abort <= 1'b0;
        end else if (w_load) begin
            r_instruction <= w_fail ? ABORT_PAYLOAD : wb.i_wb_dat;
            r_pc          <= r_adr;
            r_valid       <= 1'b1;
            r_abort       <= w_fail;
        end else if (r_valid && !i_stall) begin
            r_valid <= 1'b0;
            r_abort <= 1'b0;
        end
    end

    assign wb.o_wb_cyc    = r_cyc;
    assign wb.o_wb_stb    = r_cyc;
    assign wb.o_wb_adr    = r_adr;
    assign wb.o_wb_we     = 1'b0;
    assign wb.o_wb_sel    = 4'hF;

    assign o_instruction  = r_instruction;
    assign o_pc           = r_pc;
    assign o_valid        = r_valid;
    assign o_instr_abort  = r_abort;

endmodule

// File: tb/tb_zap_ifetch_wb_master.sv
// Bench for the instruction fetch Wishbone master: a scripted slave issues responses and queues expectations.
// Latency: expected words carry the cycle on which o_valid must rise.
// Backpressure: random stall/clear/fetch_en applied between and during transactions.
module tb_zap_ifetch_wb_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        fe, stall, clr;
    logic [31:0] instr, opc;
    logic        vld, abt;

    zap_ifetch_wb_master_if wb();

    zap_ifetch_wb_master #(.TIMEOUT(TO), .ABORT_PAYLOAD(32'd0)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_pc          (pc),
        .i_fetch_en    (fe),
        .i_stall       (stall),
        .i_clear       (clr),
        .o_instruction (instr),
        .o_valid       (vld),
        .o_instr_abort (abt),
        .o_pc          (opc),
        .wb            (wb.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        abort;
        int          when;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cycle  = 0;

    // Inputs as seen by the DUT at the most recent rising edge.
    logic        fe_q = 1'b0, st_q = 1'b0, cl_q = 1'b0;
    logic [31:0] pc_q = 32'd0;
    always @(posedge clk) begin
        cycle <= cycle + 1;
        fe_q  <= fe;
        st_q  <= stall;
        cl_q  <= clr;
        pc_q  <= pc;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    // Monitor: pops an expectation whenever a new word appears, checks hold/consume/clear otherwise.
    initial begin
        logic        p_v;
        logic [31:0] p_i, p_p;
        logic        p_a;
        exp_t        e;
        p_v = 1'b0; p_i = '0; p_p = '0; p_a = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_v = 1'b0;
            end else begin
                if (p_v && cl_q) begin
                    chk("clear_drop", {31'd0, vld}, 32'd0);
                end else if (p_v && st_q) begin
                    chk("hold_valid", {31'd0, vld}, 32'd1);
                    chk("hold_instr", instr, p_i);
                    chk("hold_pc", opc, p_p);
                    chk("hold_abort", {31'd0, abt}, {31'd0, p_a});
                end else if (p_v) begin
                    chk("consume", {31'd0, vld}, 32'd0);
                end else if (vld) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output: got instr %h pc %h, required no word", instr, opc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr", instr, e.instr);
                        chk("pc", opc, e.pc);
                        chk("abort", {31'd0, abt}, {31'd0, e.abort});
                        chk("latency", cycle, e.when);
                    end
                end
                if (exp_q.size() > 0 && exp_q[0].when < cycle) begin
                    e = exp_q.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL missing_output: got nothing by cycle %0d, required pc %h at cycle %0d",
                             cycle, e.pc, e.when);
                end
                p_v = vld; p_i = instr; p_p = opc; p_a = abt;
            end
        end
    end

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave. clr_off: edges after issue for a clear pulse (0 = none).
    task automatic run_txn(input int kind, input int d, input int clr_off, input int post_stall,
                           input logic use_pc, input logic [31:0] fixed_pc, input logic [31:0] data);
        int waited;
        int issue, resp, ce;
        exp_t e;
        waited = 0;
        clr = 1'b0;
        wb.i_wb_ack = 1'b0;
        wb.i_wb_err = 1'b0;
        while (!wb.o_wb_cyc && waited < 64) begin
            if (use_pc) begin
                fe = 1'b1; stall = 1'b0; pc = fixed_pc;
            end else begin
                fe = ($urandom_range(0, 9) < 8);
                stall = ($urandom_range(0, 9) < 3);
                pc = $urandom;
            end
            @(negedge clk);
            waited++;
        end
        if (!wb.o_wb_cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got no cyc within 64 cycles, required an issue");
            return;
        end
        issue = cycle;
        chk("issue_ok", {29'd0, fe_q, st_q, cl_q}, 32'h4);
        chk("adr", wb.o_wb_adr, {pc_q[31:2], 2'b00});
        chk("we_sel", {27'd0, wb.o_wb_we, wb.o_wb_sel}, 32'hF);
        resp = (kind == 3) ? issue + TO : issue + d + 1;
        ce   = (clr_off > 0) ? issue + clr_off : -1;
        if (ce < 0) begin
            e.instr = (kind == 0) ? data : 32'd0;
            e.pc    = {pc_q[31:2], 2'b00};
            e.abort = (kind != 0);
            e.when  = resp;
            exp_q.push_back(e);
        end
        while (cycle < resp) begin
            chk("cyc_held", {30'd0, wb.o_wb_cyc, wb.o_wb_stb}, 32'h3);
            wb.i_wb_ack = (kind == 0 || kind == 2) && (cycle + 1 == resp);
            wb.i_wb_err = (kind == 1 || kind == 2) && (cycle + 1 == resp);
            wb.i_wb_dat = (cycle + 1 == resp) ? data : $urandom;
            clr   = (cycle + 1 == ce);
            stall = ($urandom_range(0, 9) < 3);
            fe    = ($urandom_range(0, 9) < 8);
            pc    = $urandom;
            @(negedge clk);
        end
        wb.i_wb_ack = 1'b0;
        wb.i_wb_err = 1'b0;
        clr = 1'b0;
        chk("cyc_drop", {30'd0, wb.o_wb_cyc, wb.o_wb_stb}, 32'h0);
        for (int k = 0; k < post_stall; k++) begin
            stall = 1'b1;
            fe = 1'b1;
            @(negedge clk);
            chk("stall_no_issue", {31'd0, wb.o_wb_cyc}, 32'd0);
        end
        stall = 1'b0;
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        fe = 1'b0; stall = 1'b0; clr = 1'b0; pc = 32'd0;
        wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_dat = 32'd0;
        #1;
        chk("rst_valid", {31'd0, vld}, 32'd0);
        chk("rst_abort", {31'd0, abt}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", opc, 32'd0);
        chk("rst_cyc_stb", {30'd0, wb.o_wb_cyc, wb.o_wb_stb}, 32'd0);
        chk("rst_adr", wb.o_wb_adr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, 0, 0, 5, 1'b1, 32'h100, 32'hE3A00001);
        run_txn(1, 2, 0, 0, 1'b1, 32'h2004, 32'h12345678);
        run_txn(2, 1, 0, 0, 1'b1, 32'h2006, 32'hDEADBEEF);
        run_txn(0, 5, 2, 0, 1'b0, 32'd0, 32'hCAFEF00D);
        run_txn(0, 0, 0, 0, 1'b1, 32'h3000, 32'h11112222);
        run_txn(3, 0, 0, 0, 1'b1, 32'h4000, 32'h0);
        run_txn(3, 0, 3, 0, 1'b0, 32'd0, 32'h0);
        run_txn(0, 3, 4, 0, 1'b0, 32'd0, 32'h55AA55AA);

        for (int t = 0; t < 60; t++) begin
            int kind, d, span, co;
            kind = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
            d    = $urandom_range(0, 4);
            span = (kind == 3) ? TO : d + 1;
            co   = ($urandom_range(0, 9) < 2) ? $urandom_range(1, span) : 0;
            run_txn(kind, d, co, $urandom_range(0, 2), 1'b0, 32'd0, $urandom);
        end

        fe = 1'b1; stall = 1'b0; clr = 1'b0;
        waited = 0;
        while (!wb.o_wb_cyc && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_test_issue", {31'd0, wb.o_wb_cyc}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_cyc_stb", {30'd0, wb.o_wb_cyc, wb.o_wb_stb}, 32'd0);
        chk("async_valid", {31'd0, vld}, 32'd0);
        fe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            run_txn(0, t, 0, 0, 1'b0, 32'd0, $urandom);
        end

        fe = 1'b0;
        stall = 1'b0;
        repeat (12) @(negedge clk);
        chk("pending_words", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
